cv32e40p_obi_mem_responder: RTL and testbench

Memory-side responder for the core's OBI-style data (or instruction) port, i.e. the slave end of the req/gnt/rvalid handshake the core initiates. It backs a word-addressed SRAM array, inserts programmable grant and response wait states, and keeps up to OUTSTANDING accepted transactions in an in-order response queue. Used in the verification top and FPGA builds to model memory, and as the target when stressing core LSU/prefetcher back-pressure.

---
 rtl/cv32e40p_obi_mem_pkg.sv | 29 ++
 rtl/cv32e40p_obi_resp_fifo.sv | 75 +++++++
 rtl/cv32e40p_obi_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_cv32e40p_obi_mem_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_obi_mem_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_obi_mem_pkg
//
// Shared types and helpers for the OBI memory responder and its response
// queue. A response entry carries everything the responder needs to replay
// a transaction's answer later: the read data (zero for writes and for
// out-of-range accesses) and the out-of-range flag.
// -----------------------------------------------------------------------------
package cv32e40p_obi_mem_pkg;

   // One queued response, captured in the grant cycle and replayed in order.
   typedef struct packed {
      logic [31:0] rdata;
      logic        oob;
   } resp_entry_t;

   // Default array size in 32-bit words.
   localparam int unsigned DEFAULT_DEPTH_WORDS = 4096;

   // Width of the word index into an array of the given depth. A depth of one
   // still needs a one-bit index so that vectors never collapse to zero width.
   function automatic int unsigned obi_idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Word-index width for the default array size.
   localparam int unsigned DEFAULT_IDX_W = obi_idx_width(DEFAULT_DEPTH_WORDS);

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40p_obi_resp_fifo
//
// Small flop-based in-order FIFO of resp_entry_t used as the responder's
// response queue. The head entry is always visible on head_o, so the consumer
// can look at it and pop it in the same cycle.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (empties the queue)
//   push_i         write push_data_i at the tail this cycle
//   push_data_i    entry to enqueue
//   pop_i          drop the head entry this cycle
//   full_o         no free slot (the producer must not push)
//   empty_o        no valid entry (the consumer must not pop)
//   count_o        registered occupancy
//   head_o         oldest entry, straight from the storage flops
// -----------------------------------------------------------------------------
module cv32e40p_obi_resp_fifo
   import cv32e40p_obi_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  resp_entry_t push_data_i,
   input  logic        pop_i,
   output logic        full_o,
   output logic        empty_o,
   output logic [2:0]  count_o,
   output resp_entry_t head_o
);

   localparam int unsigned    PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   resp_entry_t      entries_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [2:0]       count_q;

   // Storage, pointers and occupancy. The pointers wrap explicitly at
   // DEPTH-1 so that non-power-of-two depths (such as 3) work too. Push and
   // pop in the same cycle move both pointers and leave the count alone.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         if (push_i) begin
            entries_q[wptr_q] <= push_data_i;
            wptr_q            <= (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
         end
         if (pop_i) begin
            rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Status flags and head view, all decoded from registered state.
   assign full_o  = (count_q == 3'(DEPTH));
   assign empty_o = (count_q == 3'd0);
   assign count_o = count_q;
   assign head_o  = entries_q[rptr_q];

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// cv32e40p_obi_mem_responder
//
// Slave end of the core's OBI req/gnt/rvalid handshake, backed by a
// word-addressed SRAM array. Grants can be delayed by a programmable number
// of wait cycles, and every granted transaction's response is captured in
// the grant cycle and replayed in order from a small queue after a
// programmable response delay.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   req_i            request valid from the initiator
//   gnt_o            request accepted this cycle (combinational from req_i)
//   addr_i           byte address, bits [1:0] ignored
//   we_i, be_i       write strobe and byte enables
//   wdata_i          write data
//   rvalid_o         one-cycle response strobe per granted transaction
//   rdata_o, oob_o   head response data and out-of-range flag, zero when idle
//   gnt_wait_i       cycles a request waits before it can be granted
//   rvalid_wait_i    cycles a queue head waits before it is answered
//   outstanding_o    registered response-queue occupancy
// -----------------------------------------------------------------------------
module cv32e40p_obi_mem_responder
   import cv32e40p_obi_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   input  logic [3:0]  gnt_wait_i,
   input  logic [3:0]  rvalid_wait_i,
   output logic        oob_o,
   output logic [2:0]  outstanding_o
);

   localparam int unsigned IDX_W      = obi_idx_width(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [3:0]       wcnt_q;
   logic [3:0]       wcnt_d;
   logic [3:0]       rcnt_q;
   logic [3:0]       rcnt_d;
   logic             inRange;
   logic [IDX_W-1:0] wordIdx;
   logic             fifoFull;
   logic             fifoEmpty;
   logic             pop;
   resp_entry_t      pushEntry;
   resp_entry_t      headEntry;

   // Address decode. The range test runs on 33 bits so that an array ending
   // exactly at the top of the address space cannot wrap. Because the base is
   // aligned to the array size, the low address bits are the word index.
   assign inRange = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < ADDR_LIMIT);
   assign wordIdx = addr_i[IDX_W+1:2];

   // Grant: the request must have waited long enough and the queue must have
   // room as of the registered count, so a pop this cycle never frees a slot
   // for a push this cycle. Holding the grant low while reset is asserted
   // keeps it quiet even if req_i is already high.
   assign gnt_o = rst_ni && req_i && (wcnt_q >= gnt_wait_i) && !fifoFull;

   // Grant wait counter: counts cycles of an ungranted request and restarts
   // whenever the request drops or is accepted. Saturates so a long stall
   // never wraps back below the programmed wait.
   always_comb begin
      wcnt_d = wcnt_q;
      if (!req_i || gnt_o) begin
         wcnt_d = 4'd0;
      end else if (wcnt_q != 4'hF) begin
         wcnt_d = wcnt_q + 4'd1;
      end
   end

   // Response head counter: counts how long the current head has been
   // waiting. It restarts on every pop so each new head pays the full
   // response wait, and it holds at zero while the queue is empty.
   always_comb begin
      rcnt_d = rcnt_q;
      if (pop) begin
         rcnt_d = 4'd0;
      end else if (!fifoEmpty && (rcnt_q != 4'hF)) begin
         rcnt_d = rcnt_q + 4'd1;
      end
   end

   // Both wait counters, cleared by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wcnt_q <= 4'd0;
         rcnt_q <= 4'd0;
      end else begin
         wcnt_q <= wcnt_d;
         rcnt_q <= rcnt_d;
      end
   end

   // Array write port. Only granted in-range writes touch the array, one
   // byte lane per set enable. The array itself is never reset.
   always_ff @(posedge clk_i) begin
      if (gnt_o && we_i && inRange) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[wordIdx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Response captured in the grant cycle. Reads see the array before any
   // write lands at this edge; writes answer with zero; an out-of-range
   // access answers with zero data and the oob flag.
   always_comb begin
      pushEntry = '0;
      if (!inRange) begin
         pushEntry.oob = 1'b1;
      end else if (!we_i) begin
         pushEntry.rdata = mem_q[wordIdx];
      end
   end

   cv32e40p_obi_resp_fifo #(
      .DEPTH(OUTSTANDING)
   ) u_resp_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (gnt_o),
      .push_data_i(pushEntry),
      .pop_i      (pop),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .count_o    (outstanding_o),
      .head_o     (headEntry)
   );

   // Response side. The head is answered once it has waited long enough and
   // leaves the queue in that same cycle. Data and flag come only from the
   // queue flops and are forced to zero between responses.
   assign rvalid_o = !fifoEmpty && (rcnt_q >= rvalid_wait_i);
   assign pop      = rvalid_o;
   assign rdata_o  = rvalid_o ? headEntry.rdata : 32'h0;
   assign oob_o    = rvalid_o ? headEntry.oob   : 1'b0;

   // The initiator must keep its request and its attributes steady from the
   // first cycle of a request until that request is granted.
   property pReqStableUntilGnt;
      @(posedge clk_i) disable iff (!rst_ni)
         (req_i && !gnt_o) |=> (req_i && $stable({addr_i, we_i, be_i, wdata_i}));
   endproperty

   assert property (pReqStableUntilGnt)
      else $error("request attributes changed before grant");

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_obi_mem_responder
//
// Self-checking bench for the OBI memory responder: a table of single-cycle
// vectors for the basic read/write/byte-enable/out-of-range behaviour,
// hand-written sequences for wait states, back-pressure and reset, and a
// randomized phase scored against a timestamp-based reference model.
// -----------------------------------------------------------------------------
module tb_cv32e40p_obi_mem_responder;
   import cv32e40p_obi_mem_pkg::*;

   localparam int OUTST = 2;

   logic        clk;
   logic        rstN;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic [3:0]  gntWait;
   logic [3:0]  rvalidWait;
   logic        oob;
   logic [2:0]  outstanding;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        expGnt;
      logic        expRvalid;
      logic [31:0] expRdata;
      logic        expOob;
      logic [2:0]  expOut;
   } vec_t;

   vec_t vecs [11];

   int          gntCyc [4];
   int          rvCyc [4];
   logic [31:0] rdAddr [4];
   logic [31:0] expData [4];
   logic        expOobArr [4];
   int          k;
   int          rvIdx;
   int          expOutN;

   logic        reqActive;
   int          reqStart;
   int          headStart;
   int          pending;
   int          preIdx;
   int          opIdx;
   logic        opWe;
   logic [3:0]  opBe;
   logic [31:0] opAddr;
   logic [31:0] opWdata;
   logic        expGnt;
   logic        expRv;
   resp_entry_t expQ [$];
   resp_entry_t headResp;
   resp_entry_t newResp;
   logic [31:0] refMem [9];
   logic [31:0] oobAddrs [4];

   cv32e40p_obi_mem_responder #(
      .DEPTH_WORDS(4096),
      .BASE_ADDR  (32'h0000_0000),
      .OUTSTANDING(OUTST)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .req_i        (req),
      .gnt_o        (gnt),
      .addr_i       (addr),
      .we_i         (we),
      .be_i         (be),
      .wdata_i      (wdata),
      .rvalid_o     (rvalid),
      .rdata_o      (rdata),
      .gnt_wait_i   (gntWait),
      .rvalid_wait_i(rvalidWait),
      .oob_o        (oob),
      .outstanding_o(outstanding)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends even if something stalls forever.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one request cycle worth of initiator inputs.
   task automatic applyStimulus(input logic r, input logic [31:0] a, input logic w,
                                input logic [3:0] b, input logic [31:0] d);
      req   = r;
      addr  = a;
      we    = w;
      be    = b;
      wdata = d;
   endtask

   // Compare one observed value against the bench's expectation.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
      end
   endtask

   // Move to just after the next rising edge, where inputs are changed.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Byte address of reference word i: eight words at 0x1000 plus the very
   // last word of the array, so the top boundary is exercised too.
   function automatic logic [31:0] refAddr(input int i);
      return (i < 8) ? (32'h1000 + 32'(i) * 32'd4) : 32'h0000_3FFC;
   endfunction

   initial begin
      // Per-cycle vectors with zero wait states. Each response shows up the
      // cycle after its grant, so every row checks the previous row's answer.
      vecs[0]  = '{1'b1, 32'h0000_0000, 1'b1, 4'hF, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h0,          1'b0, 3'd0};
      vecs[1]  = '{1'b1, 32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0,          1'b0, 3'd1};
      vecs[2]  = '{1'b1, 32'h0000_1000, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0,          1'b0, 3'd1};
      vecs[3]  = '{1'b1, 32'h0000_1004, 1'b1, 4'hF, 32'h1122_3344, 1'b1, 1'b1, 32'hDEAD_BEEF,  1'b0, 3'd1};
      vecs[4]  = '{1'b1, 32'h0000_1004, 1'b1, 4'h5, 32'hAABB_CCDD, 1'b1, 1'b1, 32'h0,          1'b0, 3'd1};
      vecs[5]  = '{1'b1, 32'h0000_1004, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0,          1'b0, 3'd1};
      vecs[6]  = '{1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 32'h11BB_33DD,  1'b0, 3'd1};
      vecs[7]  = '{1'b1, 32'h0001_0000, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0,          1'b1, 3'd1};
      vecs[8]  = '{1'b1, 32'h0000_0000, 1'b0, 4'h0, 32'h0,         1'b1, 1'b1, 32'h0,          1'b1, 3'd1};
      vecs[9]  = '{1'b0, 32'h0000_0000, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 32'h5A5A_5A5A,  1'b0, 3'd1};
      vecs[10] = '{1'b0, 32'h0000_0000, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b0, 3'd0};

      // Back-pressure schedule for four reads with a five-cycle response wait
      // and a two-deep queue: the third and fourth grants each wait for a pop.
      gntCyc    = '{0, 1, 7, 13};
      rvCyc     = '{6, 12, 18, 24};
      rdAddr    = '{32'h0000_1000, 32'h0000_1004, 32'h0001_0000, 32'h0000_0000};
      expData   = '{32'hDEAD_BEEF, 32'h11BB_33DD, 32'h0, 32'h5A5A_5A5A};
      expOobArr = '{1'b0, 1'b0, 1'b1, 1'b0};

      // Out-of-range addresses: the first word past the array, and three
      // that alias onto the reference words if the range check were ignored.
      oobAddrs = '{32'(1) << (DEFAULT_IDX_W + 2), 32'h0000_5000, 32'h0001_1004, 32'hFFFF_1008};

      // Reset with a request already pending: everything must stay quiet.
      rstN       = 1'b0;
      gntWait    = 4'd0;
      rvalidWait = 4'd0;
      applyStimulus(1'b1, 32'h0000_1000, 1'b0, 4'h0, 32'h0);
      #2;
      checkOutput("reset.gnt", 32'(gnt), 32'd0);
      checkOutput("reset.rvalid", 32'(rvalid), 32'd0);
      checkOutput("reset.rdata", rdata, 32'h0);
      checkOutput("reset.oob", 32'(oob), 32'd0);
      checkOutput("reset.outstanding", 32'(outstanding), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

      // Table-driven vectors: writes, read-after-write, byte enables and
      // out-of-range accesses, all with zero wait states.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].req, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata);
         @(negedge clk);
         checkOutput($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(vecs[i].expGnt));
         checkOutput($sformatf("vec%0d.rvalid", i), 32'(rvalid), 32'(vecs[i].expRvalid));
         checkOutput($sformatf("vec%0d.rdata", i), rdata, vecs[i].expRdata);
         checkOutput($sformatf("vec%0d.oob", i), 32'(oob), 32'(vecs[i].expOob));
         checkOutput($sformatf("vec%0d.outstanding", i), 32'(outstanding), 32'(vecs[i].expOut));
         nextCycle();
      end

      // Grant wait 3 and response wait 2 with the request held from cycle 0:
      // grant lands in cycle 3, the response in cycle 6.
      gntWait    = 4'd3;
      rvalidWait = 4'd2;
      for (int c = 0; c < 9; c++) begin
         applyStimulus(c <= 3, 32'h0000_1000, 1'b0, 4'h0, 32'h0);
         @(negedge clk);
         checkOutput($sformatf("wait.c%0d.gnt", c), 32'(gnt), 32'(c == 3));
         checkOutput($sformatf("wait.c%0d.rvalid", c), 32'(rvalid), 32'(c == 6));
         checkOutput($sformatf("wait.c%0d.rdata", c), rdata, (c == 6) ? 32'hDEAD_BEEF : 32'h0);
         checkOutput($sformatf("wait.c%0d.outstanding", c), 32'(outstanding), 32'(c >= 4 && c <= 6));
         nextCycle();
      end

      // Back-pressure: four reads offered back to back against a full queue.
      gntWait    = 4'd0;
      rvalidWait = 4'd5;
      k          = 0;
      rvIdx      = 0;
      for (int c = 0; c < 28; c++) begin
         applyStimulus(k < 4, rdAddr[(k < 4) ? k : 3], 1'b0, 4'h0, 32'h0);
         @(negedge clk);
         expGnt  = (k < 4) && (gntCyc[(k < 4) ? k : 3] == c);
         expRv   = (rvIdx < 4) && (rvCyc[(rvIdx < 4) ? rvIdx : 3] == c);
         expOutN = 0;
         for (int j = 0; j < 4; j++) begin
            if (gntCyc[j] < c) expOutN++;
            if (rvCyc[j] < c) expOutN--;
         end
         checkOutput($sformatf("bp.c%0d.gnt", c), 32'(gnt), 32'(expGnt));
         checkOutput($sformatf("bp.c%0d.rvalid", c), 32'(rvalid), 32'(expRv));
         checkOutput($sformatf("bp.c%0d.rdata", c), rdata, expRv ? expData[rvIdx] : 32'h0);
         checkOutput($sformatf("bp.c%0d.oob", c), 32'(oob), expRv ? 32'(expOobArr[rvIdx]) : 32'd0);
         checkOutput($sformatf("bp.c%0d.outstanding", c), 32'(outstanding), 32'(expOutN));
         if (expGnt) k++;
         if (expRv) rvIdx++;
         nextCycle();
      end

      // Reset in the middle of traffic: two responses queued and a third
      // request waiting. Reset must clear everything at once and no stale
      // response may appear afterwards, while the array keeps its contents.
      gntWait    = 4'd0;
      rvalidWait = 4'd8;
      applyStimulus(1'b1, 32'h0000_1000, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput("rst.gnt0", 32'(gnt), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h0000_1004, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput("rst.gnt1", 32'(gnt), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 32'h0000_0000, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput("rst.fullgnt", 32'(gnt), 32'd0);
      checkOutput("rst.fullcount", 32'(outstanding), 32'd2);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("rst.async.gnt", 32'(gnt), 32'd0);
      checkOutput("rst.async.rvalid", 32'(rvalid), 32'd0);
      checkOutput("rst.async.outstanding", 32'(outstanding), 32'd0);
      checkOutput("rst.async.rdata", rdata, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         checkOutput($sformatf("rst.quiet%0d.rvalid", i), 32'(rvalid), 32'd0);
         nextCycle();
      end
      rvalidWait = 4'd0;
      applyStimulus(1'b1, 32'h0000_1004, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput("rst.after.gnt", 32'(gnt), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      checkOutput("rst.after.rvalid", 32'(rvalid), 32'd1);
      checkOutput("rst.after.rdata", rdata, 32'h11BB_33DD);
      nextCycle();

      // Randomized traffic against a reference model kept in time stamps:
      // a request is due gntWait cycles after it started (if fewer than
      // OUTST responses are pending), and the head response is due rvalidWait
      // cycles after it became head. The first nine operations preload the
      // reference words so every later read has a known answer.
      preIdx  = 0;
      opAddr  = 32'h0;
      opWe    = 1'b0;
      opBe    = 4'h0;
      opWdata = 32'h0;
      opIdx   = 0;
      for (int ph = 0; ph < 3; ph++) begin
         gntWait    = 4'($urandom_range(0, 3));
         rvalidWait = 4'($urandom_range(0, 4));
         reqActive  = 1'b0;
         reqStart   = 0;
         headStart  = 0;
         expQ.delete();
         for (int n = 0; n < 500; n++) begin
            if (n >= 150 && !reqActive && expQ.size() == 0) break;
            if (!reqActive && n < 150 && (preIdx < 9 || $urandom_range(0, 9) < 6)) begin
               if (preIdx < 9) begin
                  opIdx = preIdx;
                  opWe  = 1'b1;
                  opBe  = 4'hF;
                  preIdx++;
               end else begin
                  opIdx = int'($urandom_range(0, 9));
                  opWe  = 1'($urandom_range(0, 1));
                  opBe  = 4'($urandom_range(0, 15));
               end
               opWdata = $urandom();
               if (opIdx < 9) opAddr = refAddr(opIdx) | 32'($urandom_range(0, 3));
               else           opAddr = oobAddrs[$urandom_range(0, 3)];
               reqActive = 1'b1;
               reqStart  = n;
            end
            applyStimulus(reqActive, opAddr, opWe, opBe, opWdata);
            @(negedge clk);
            pending  = expQ.size();
            expGnt   = reqActive && ((n - reqStart) >= int'(gntWait)) && (pending < OUTST);
            expRv    = (pending > 0) && (n >= headStart + int'(rvalidWait));
            headResp = expRv ? expQ[0] : '{rdata: 32'h0, oob: 1'b0};
            checkOutput($sformatf("rnd%0d.n%0d.gnt", ph, n), 32'(gnt), 32'(expGnt));
            checkOutput($sformatf("rnd%0d.n%0d.rvalid", ph, n), 32'(rvalid), 32'(expRv));
            checkOutput($sformatf("rnd%0d.n%0d.rdata", ph, n), rdata, headResp.rdata);
            checkOutput($sformatf("rnd%0d.n%0d.oob", ph, n), 32'(oob), 32'(headResp.oob));
            checkOutput($sformatf("rnd%0d.n%0d.outstanding", ph, n), 32'(outstanding), 32'(pending));
            if (expRv) begin
               void'(expQ.pop_front());
               headStart = n + 1;
            end
            if (expGnt) begin
               if (opIdx > 8) begin
                  newResp = '{rdata: 32'h0, oob: 1'b1};
               end else if (opWe) begin
                  for (int b = 0; b < 4; b++) begin
                     if (opBe[b]) refMem[opIdx][8*b +: 8] = opWdata[8*b +: 8];
                  end
                  newResp = '{rdata: 32'h0, oob: 1'b0};
               end else begin
                  newResp = '{rdata: refMem[opIdx], oob: 1'b0};
               end
               if (expQ.size() == 0) headStart = n + 1;
               expQ.push_back(newResp);
               reqActive = 1'b0;
            end
            nextCycle();
         end
         checkOutput($sformatf("rnd%0d.drained", ph), 32'(expQ.size()) + 32'(reqActive), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
